painterengine_gpu_writer_scheduler: RTL and testbench
=====================================================

Name: painterengine_gpu_writer_scheduler

Overview:
Sequences and shares the 4-route GPU DMA writer between four requesters (channels 0..3).
- Grants one channel at a time, round-robin.
- Drives the writer's one-hot router and its active-low reset, which re-arms the writer for each job.
- Watches writer done/error, adds a watchdog timeout, and reports per-channel completion with status.
- Sits between the GPU command front-end and the DMA writer; the grant vector also steers the address, length and data muxes.

Parameters:
PARAM_CHANNELS, 4, number of requesters; fixed at 4 to match the writer router width.
PARAM_RESET_CYCLES, 4, cycles the writer is held in reset before each job (min 1).
PARAM_TIMEOUT_WIDTH, 24, width of the watchdog counter.
PARAM_TIMEOUT_CYCLES, 24'd1048576, BUSY cycles allowed before a timeout is forced.

Ports:
i_wire_clock  in  1  single clock; all logic on the rising edge
i_wire_reset  in  1  asynchronous, active-high reset
i_wire_request  in  4  per-channel job request, level; held until that channel's ack
o_wire_grant  out  4  one-hot owner of the writer; 0 when idle
o_wire_ack  out  4  one-cycle pulse on job end (done, error or timeout)
o_wire_status_error  out  4  pulses together with ack when the job ended in error or timeout
o_wire_error_type  out  3  error type of the last failed job, held until the next failure
o_wire_busy  out  1  high from grant until ack
o_wire_writer_resetn  out  1  drives the writer's active-low reset
o_wire_writer_router  out  4  drives the writer's router input
i_wire_writer_done  in  1  writer done
i_wire_writer_error  in  1  writer error
i_wire_writer_error_type  in  3  writer error type

Behaviour:
- Reset (async, active-high): every output goes to 0 (grant, ack, status_error, error_type, busy, writer_resetn, writer_router). State = IDLE; round-robin pointer = channel 0.
- Writer is held in reset (writer_resetn=0) in every state except BUSY. All outputs are registered.
- IDLE: if request != 0, the round-robin arbiter picks the first requesting channel starting at pointer.
  - Register grant and router to that one-hot value; set busy=1.
  - Load reset counter = PARAM_RESET_CYCLES; go to KICK.
  - If request == 0, stay in IDLE.
- KICK: writer_resetn=0 and router valid. Decrement the counter; at 0, set writer_resetn=1, clear the watchdog, go to BUSY.
  - Router is stable at least PARAM_RESET_CYCLES cycles before reset release.
- BUSY: writer_resetn=1. Watchdog increments each cycle. Priority order:
  - error=1 → latch error_type := i_wire_writer_error_type, failed flag=1, go to COMPLETE. Error wins over a simultaneous done.
  - else done=1 → failed flag=0, go to COMPLETE.
  - else watchdog == PARAM_TIMEOUT_CYCLES-1 → error_type := 3'h7 (TIMEOUT), failed flag=1, go to COMPLETE.
  - done/error are ignored outside BUSY, since the writer is in reset there.
- COMPLETE (exactly 1 cycle):
  - ack[g]=1; status_error[g]=failed flag.
  - writer_resetn=0; router=0; grant=0; busy=0.
  - pointer := (g+1) mod 4; go to IDLE.
- Request handshake:
  - The requester must drop request by the edge after ack. A request still high when IDLE next samples is a new job.
  - A request dropped mid-job is ignored; the job runs to COMPLETE and ack is still issued.
- Fairness: with all four requesting continuously, grants go 0,1,2,3,0,...
- Latency from request to writer_resetn rising is 1 + PARAM_RESET_CYCLES cycles. Minimum job overhead is PARAM_RESET_CYCLES + 3 cycles.
- Watchdog saturates and never wraps. The reset counter must be ≥ 1; PARAM_RESET_CYCLES = 0 is illegal (assert).
- Reset mid-job: abort immediately. No ack is issued and the writer is forced into reset. Requesters must re-request.

Decomposition:
- Shared package painterengine_gpu_pkg holds:
  - scheduler state encodings (IDLE, KICK, BUSY, COMPLETE);
  - the channel count constant (4);
  - writer error type codes, plus GPU_ERR_TIMEOUT = 3'h7;
  - the one-hot router constants.
- One sub-module: painterengine_gpu_rr_arbiter.
  - Combinational 4-way round-robin: inputs request and pointer; outputs one-hot grant and any_request.
  - The scheduler instantiates it once and registers its outputs.

Test Plan:
- Single request: request=4'b0100, writer done 10 cycles after resetn rises.
  → router=4'b0100 throughout KICK/BUSY; resetn low for 4 cycles, then high; ack=4'b0100 for 1 cycle; status_error=0; busy low after COMPLETE.
- All four requesting, each acked and re-requesting.
  → grant sequence 0001, 0010, 0100, 1000, 0001; no channel is granted twice in a row.
- Writer error, type 3'h2, on channel 1, with done asserted the same cycle.
  → ack=4'b0010, status_error=4'b0010, error_type=3'h2; next job on channel 2 proceeds.
- No done/error, PARAM_TIMEOUT_CYCLES=64.
  → COMPLETE after 64 BUSY cycles; status_error set; error_type=3'h7; writer_resetn back to 0.
- Reset asserted mid-BUSY on channel 3.
  → all outputs 0 immediately, no ack; after release a request on channel 0 is granted first.
- Channel 2 drops request during BUSY.
  → job completes; ack=4'b0100 still pulses; IDLE then arbitrates the remaining requests.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_pkg: shared encodings for the GPU writer scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package painterengine_gpu_pkg;

  localparam int GPU_CHANNELS = 4;

  typedef enum logic [1:0] {
    SCHED_IDLE     = 2'd0,
    SCHED_KICK     = 2'd1,
    SCHED_BUSY     = 2'd2,
    SCHED_COMPLETE = 2'd3
  } sched_state_e;

  localparam logic [2:0] GPU_ERR_NONE    = 3'h0;
  localparam logic [2:0] GPU_ERR_ADDRESS = 3'h1;
  localparam logic [2:0] GPU_ERR_BUS     = 3'h2;
  localparam logic [2:0] GPU_ERR_LENGTH  = 3'h3;
  localparam logic [2:0] GPU_ERR_TIMEOUT = 3'h7;

  localparam logic [3:0] ROUTER_NONE = 4'b0000;
  localparam logic [3:0] ROUTER_CH0  = 4'b0001;
  localparam logic [3:0] ROUTER_CH1  = 4'b0010;
  localparam logic [3:0] ROUTER_CH2  = 4'b0100;
  localparam logic [3:0] ROUTER_CH3  = 4'b1000;

  function automatic logic [1:0] onehot_to_index(input logic [3:0] onehot);
    logic [1:0] index;
    index = 2'd0;
    case (onehot)
      ROUTER_CH1: index = 2'd1;
      ROUTER_CH2: index = 2'd2;
      ROUTER_CH3: index = 2'd3;
      default:    index = 2'd0;
    endcase
    return index;
  endfunction

endpackage

`default_nettype wire

// File: rtl/painterengine_gpu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_rr_arbiter: combinational 4-way round-robin pick.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module painterengine_gpu_rr_arbiter
  import painterengine_gpu_pkg::*;
(
  input  logic [3:0] request,
  input  logic [1:0] pointer,
  output logic [3:0] grant,
  output logic       any_request
);

  logic       found;
  logic [1:0] index;

  // Scan starting at the pointer; the first requester found wins.
  always_comb begin
    grant = ROUTER_NONE;
    found = 1'b0;
    index = pointer;
    for (int i = 0; i < GPU_CHANNELS; i++) begin
      index = pointer + 2'(i);
      if (!found && request[index]) begin
        grant[index] = 1'b1;
        found        = 1'b1;
      end
    end
    any_request = |request;
  end

endmodule

`default_nettype wire

// File: rtl/painterengine_gpu_writer_scheduler.sv
// ----------------------------------------------------------------------------
// painterengine_gpu_writer_scheduler: round-robin owner of the GPU DMA writer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module painterengine_gpu_writer_scheduler
  import painterengine_gpu_pkg::*;
#(
  parameter int                             PARAM_CHANNELS       = 4,
  parameter int                             PARAM_RESET_CYCLES   = 4,
  parameter int                             PARAM_TIMEOUT_WIDTH  = 24,
  parameter logic [PARAM_TIMEOUT_WIDTH-1:0] PARAM_TIMEOUT_CYCLES = 24'd1048576
) (
  input  logic       i_wire_clock,
  input  logic       i_wire_reset,
  input  logic [3:0] i_wire_request,
  output logic [3:0] o_wire_grant,
  output logic [3:0] o_wire_ack,
  output logic [3:0] o_wire_status_error,
  output logic [2:0] o_wire_error_type,
  output logic       o_wire_busy,
  output logic       o_wire_writer_resetn,
  output logic [3:0] o_wire_writer_router,
  input  logic       i_wire_writer_done,
  input  logic       i_wire_writer_error,
  input  logic [2:0] i_wire_writer_error_type
);

  localparam int RESET_COUNT_WIDTH =
    (PARAM_RESET_CYCLES < 1) ? 1 : $clog2(PARAM_RESET_CYCLES + 1);
  localparam logic [RESET_COUNT_WIDTH-1:0] RESET_LOAD = RESET_COUNT_WIDTH'(PARAM_RESET_CYCLES);
  localparam logic [RESET_COUNT_WIDTH-1:0] RESET_LAST = RESET_COUNT_WIDTH'(1);
  localparam logic [PARAM_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    PARAM_TIMEOUT_CYCLES - PARAM_TIMEOUT_WIDTH'(1);
  localparam logic [PARAM_TIMEOUT_WIDTH-1:0] WATCHDOG_MAX = '1;

  if (PARAM_RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("PARAM_RESET_CYCLES must be at least 1");
  end

  if (PARAM_CHANNELS != GPU_CHANNELS) begin : g_bad_channels
    $error("PARAM_CHANNELS must equal the writer router width of 4");
  end

  sched_state_e                   state;
  sched_state_e                   next_state;
  logic [1:0]                     pointer;
  logic [1:0]                     pointer_next;
  logic [RESET_COUNT_WIDTH-1:0]   reset_count;
  logic [RESET_COUNT_WIDTH-1:0]   reset_count_next;
  logic [PARAM_TIMEOUT_WIDTH-1:0] watchdog;
  logic [PARAM_TIMEOUT_WIDTH-1:0] watchdog_next;
  logic [3:0]                     grant_next;
  logic [3:0]                     ack_next;
  logic [3:0]                     status_next;
  logic [2:0]                     error_type_next;
  logic                           busy_next;
  logic                           resetn_next;
  logic [3:0]                     router_next;
  logic [3:0]                     arb_grant;
  logic                           arb_any;
  logic                           job_end;
  logic                           job_failed;

  painterengine_gpu_rr_arbiter u_arbiter (
    .request     (i_wire_request),
    .pointer     (pointer),
    .grant       (arb_grant),
    .any_request (arb_any)
  );

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state                <= SCHED_IDLE;
      pointer              <= 2'd0;
      reset_count          <= '0;
      watchdog             <= '0;
      o_wire_grant         <= ROUTER_NONE;
      o_wire_ack           <= 4'b0000;
      o_wire_status_error  <= 4'b0000;
      o_wire_error_type    <= GPU_ERR_NONE;
      o_wire_busy          <= 1'b0;
      o_wire_writer_resetn <= 1'b0;
      o_wire_writer_router <= ROUTER_NONE;
    end else begin
      state                <= next_state;
      pointer              <= pointer_next;
      reset_count          <= reset_count_next;
      watchdog             <= watchdog_next;
      o_wire_grant         <= grant_next;
      o_wire_ack           <= ack_next;
      o_wire_status_error  <= status_next;
      o_wire_error_type    <= error_type_next;
      o_wire_busy          <= busy_next;
      o_wire_writer_resetn <= resetn_next;
      o_wire_writer_router <= router_next;
    end
  end

  always_comb begin
    next_state       = state;
    pointer_next     = pointer;
    reset_count_next = reset_count;
    watchdog_next    = watchdog;
    grant_next       = o_wire_grant;
    ack_next         = 4'b0000;
    status_next      = 4'b0000;
    error_type_next  = o_wire_error_type;
    busy_next        = o_wire_busy;
    resetn_next      = 1'b0;
    router_next      = o_wire_writer_router;
    job_end          = 1'b0;
    job_failed       = 1'b0;

    case (state)
      SCHED_IDLE: begin
        if (arb_any) begin
          grant_next       = arb_grant;
          router_next      = arb_grant;
          busy_next        = 1'b1;
          reset_count_next = RESET_LOAD;
          next_state       = SCHED_KICK;
        end
      end

      SCHED_KICK: begin
        reset_count_next = reset_count - RESET_LAST;
        if (reset_count <= RESET_LAST) begin
          resetn_next   = 1'b1;
          watchdog_next = '0;
          next_state    = SCHED_BUSY;
        end
      end

      SCHED_BUSY: begin
        resetn_next = 1'b1;
        if (watchdog != WATCHDOG_MAX) begin
          watchdog_next = watchdog + PARAM_TIMEOUT_WIDTH'(1);
        end
        // Error outranks done; the watchdog only fires when the writer is silent.
        if (i_wire_writer_error) begin
          job_end         = 1'b1;
          job_failed      = 1'b1;
          error_type_next = i_wire_writer_error_type;
        end else if (i_wire_writer_done) begin
          job_end = 1'b1;
        end else if (watchdog == TIMEOUT_LAST) begin
          job_end         = 1'b1;
          job_failed      = 1'b1;
          error_type_next = GPU_ERR_TIMEOUT;
        end
        if (job_end) begin
          ack_next     = o_wire_grant;
          status_next  = job_failed ? o_wire_grant : 4'b0000;
          resetn_next  = 1'b0;
          router_next  = ROUTER_NONE;
          grant_next   = ROUTER_NONE;
          busy_next    = 1'b0;
          pointer_next = onehot_to_index(o_wire_grant) + 2'd1;
          next_state   = SCHED_COMPLETE;
        end
      end

      SCHED_COMPLETE: begin
        next_state = SCHED_IDLE;
      end

      default: begin
        next_state = SCHED_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_painterengine_gpu_writer_scheduler: directed checks of the writer scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_painterengine_gpu_writer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       err = 1'b0;
  logic [2:0] etype = 3'h0;
  logic [3:0] grant;
  logic [3:0] ack;
  logic [3:0] status;
  logic [2:0] error_type;
  logic       busy;
  logic       resetn;
  logic [3:0] router;

  int checks = 0;
  int failures = 0;

  painterengine_gpu_writer_scheduler #(
    .PARAM_CHANNELS       (4),
    .PARAM_RESET_CYCLES   (4),
    .PARAM_TIMEOUT_WIDTH  (24),
    .PARAM_TIMEOUT_CYCLES (24'd64)
  ) dut (
    .i_wire_clock             (clk),
    .i_wire_reset             (rst),
    .i_wire_request           (req),
    .o_wire_grant             (grant),
    .o_wire_ack               (ack),
    .o_wire_status_error      (status),
    .o_wire_error_type        (error_type),
    .o_wire_busy              (busy),
    .o_wire_writer_resetn     (resetn),
    .o_wire_writer_router     (router),
    .i_wire_writer_done       (done),
    .i_wire_writer_error      (err),
    .i_wire_writer_error_type (etype)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, {4'h0, grant}, 8'h00);
    chk({tag, "_ack"}, {4'h0, ack}, 8'h00);
    chk({tag, "_status"}, {4'h0, status}, 8'h00);
    chk({tag, "_etype"}, {5'h0, error_type}, 8'h00);
    chk({tag, "_busy"}, {7'h0, busy}, 8'h00);
    chk({tag, "_resetn"}, {7'h0, resetn}, 8'h00);
    chk({tag, "_router"}, {4'h0, router}, 8'h00);
  endtask

  // Bounded wait for the next grant; a missing grant shows up in the grant check.
  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      if (grant !== 4'b0000) break;
      tick();
    end
  endtask

  task automatic run_job(input string tag, input logic [3:0] ch, input int busy_cycles,
                         input logic [3:0] mid_req, input logic d, input logic e,
                         input logic [2:0] et, input logic [2:0] exp_et);
    wait_grant();
    chk({tag, "_grant"}, {4'h0, grant}, {4'h0, ch});
    chk({tag, "_router"}, {4'h0, router}, {4'h0, ch});
    chk({tag, "_busy"}, {7'h0, busy}, 8'h01);
    chk({tag, "_kick_resetn"}, {7'h0, resetn}, 8'h00);
    repeat (3) tick();
    chk({tag, "_kick_end_resetn"}, {7'h0, resetn}, 8'h00);
    chk({tag, "_kick_router"}, {4'h0, router}, {4'h0, ch});
    tick();
    chk({tag, "_busy_resetn"}, {7'h0, resetn}, 8'h01);
    req = mid_req;
    repeat (busy_cycles) tick();
    chk({tag, "_busy_noack"}, {4'h0, ack}, 8'h00);
    chk({tag, "_busy_router"}, {4'h0, router}, {4'h0, ch});
    done = d;
    err = e;
    etype = et;
    tick();
    done = 1'b0;
    err = 1'b0;
    etype = 3'h0;
    chk({tag, "_ack"}, {4'h0, ack}, {4'h0, ch});
    chk({tag, "_status"}, {4'h0, status}, e ? {4'h0, ch} : 8'h00);
    chk({tag, "_etype"}, {5'h0, error_type}, {5'h0, exp_et});
    chk({tag, "_done_busy"}, {7'h0, busy}, 8'h00);
    chk({tag, "_done_resetn"}, {7'h0, resetn}, 8'h00);
    chk({tag, "_done_router"}, {4'h0, router}, 8'h00);
    chk({tag, "_done_grant"}, {4'h0, grant}, 8'h00);
  endtask

  initial begin
    logic [3:0] rr_expect [5];
    rr_expect[0] = 4'b0001;
    rr_expect[1] = 4'b0010;
    rr_expect[2] = 4'b0100;
    rr_expect[3] = 4'b1000;
    rr_expect[4] = 4'b0001;

    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single request on channel 2, done ten cycles after reset release.
    req = 4'b0100;
    run_job("single", 4'b0100, 9, 4'b0100, 1'b1, 1'b0, 3'h0, 3'h0);
    req = 4'b0000;
    tick();
    chk("single_ack_clear", {4'h0, ack}, 8'h00);
    chk("single_idle_busy", {7'h0, busy}, 8'h00);

    // Fresh reset so the round-robin pointer starts at channel 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      run_job("rr", rr_expect[k], 2, 4'b1111, 1'b1, 1'b0, 3'h0, 3'h0);
    end

    // Error with a simultaneous done on channel 1, then channel 2 runs clean.
    req = 4'b0110;
    run_job("err", 4'b0010, 3, 4'b0110, 1'b1, 1'b1, 3'h2, 3'h2);
    req = 4'b0100;
    run_job("after_err", 4'b0100, 3, 4'b0100, 1'b1, 1'b0, 3'h0, 3'h2);

    // Watchdog: 64 silent BUSY cycles on channel 0.
    req = 4'b0001;
    wait_grant();
    chk("to_grant", {4'h0, grant}, 8'h01);
    repeat (4) tick();
    chk("to_busy_resetn", {7'h0, resetn}, 8'h01);
    repeat (63) tick();
    chk("to_pre_ack", {4'h0, ack}, 8'h00);
    chk("to_pre_resetn", {7'h0, resetn}, 8'h01);
    chk("to_pre_busy", {7'h0, busy}, 8'h01);
    tick();
    chk("to_ack", {4'h0, ack}, 8'h01);
    chk("to_status", {4'h0, status}, 8'h01);
    chk("to_etype", {5'h0, error_type}, 8'h07);
    chk("to_resetn", {7'h0, resetn}, 8'h00);
    chk("to_busy", {7'h0, busy}, 8'h00);
    req = 4'b0000;

    // Reset in the middle of a channel 3 job.
    req = 4'b1000;
    wait_grant();
    chk("mid_grant", {4'h0, grant}, 8'h08);
    repeat (4) tick();
    chk("mid_busy_resetn", {7'h0, resetn}, 8'h01);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    req = 4'b1001;
    tick();
    chk_all_zero("mid_rst_held");
    rst = 1'b0;
    run_job("post_rst", 4'b0001, 2, 4'b1000, 1'b1, 1'b0, 3'h0, 3'h0);
    req = 4'b0000;
    tick();
    tick();
    chk("post_rst_idle_grant", {4'h0, grant}, 8'h00);

    // Channel 2 withdraws mid-job; channel 0 is served next.
    req = 4'b0101;
    run_job("drop", 4'b0100, 4, 4'b0001, 1'b1, 1'b0, 3'h0, 3'h0);
    run_job("remaining", 4'b0001, 2, 4'b0001, 1'b1, 1'b0, 3'h0, 3'h0);
    req = 4'b0000;
    tick();
    tick();
    chk("final_grant", {4'h0, grant}, 8'h00);
    chk("final_busy", {7'h0, busy}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
